// File: rtl/ptpv2_defines.sv
// Shared PTPv2 time-format constants and the packed timestamp record used by
// the capture pipeline and its queue.
package ptpv2_defines;

   localparam int SEC_W = 48;
   localparam int NS_W  = 32;
   localparam int FNS_W = 16;
   localparam int STD_W = 80;

   localparam logic [NS_W-1:0] NS_PER_SEC = 32'd1_000_000_000;

   typedef struct packed {
      logic [SEC_W-1:0] sec;
      logic [NS_W-1:0]  ns;
   } ptp_time_t;

endpackage

// File: rtl/ptp_ts_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count.
// Head data reads as zero while empty; a push into a full queue is dropped and flagged.
module ptp_ts_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop_req,
   output logic             valid,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      cnt,
   output logic             drop
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             pop;
   logic             wr;

   assign full  = (count == FULL_CNT);
   assign valid = (count != '0);
   assign pop   = valid & pop_req;
   // A full queue still accepts a write when the head leaves in the same cycle.
   assign wr    = push & (~full | pop);
   assign drop  = push & full & ~pop;
   assign cnt   = count;
   assign dout  = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ptp_ts_capture.sv
// Start-of-frame timestamp capture: snapshots RTC time, applies latency
// correction with ns-to-seconds carry, and queues tagged results.
module ptp_ts_capture
   import ptpv2_defines::*;
#(
   parameter int FIFO_AW = 2,
   parameter int TAG_W   = 16
) (
   input  logic               rtc_clk,
   input  logic               rtc_rst_n,
   input  logic [STD_W-1:0]   rtc_std_i,
   input  logic [FNS_W-1:0]   rtc_fns_i,
   input  logic               sof_i,
   input  logic [TAG_W-1:0]   tag_i,
   input  logic               lat_en_i,
   input  logic [15:0]        lat_ns_i,
   input  logic               ts_ready_i,
   output logic               ts_valid_o,
   output logic [STD_W-1:0]   ts_std_o,
   output logic [FNS_W-1:0]   ts_fns_o,
   output logic [TAG_W-1:0]   ts_tag_o,
   output logic [FIFO_AW:0]   fifo_cnt_o,
   output logic               ovf_o,
   input  logic               ovf_clr_i
);

   localparam int ENTRY_W = STD_W + FNS_W + TAG_W;

   // Input ns < 1e9 and latency < 2^16, so a single subtraction always normalises.
   function automatic ptp_time_t normalize(input logic [SEC_W-1:0] sec,
                                           input logic [NS_W:0]    ns_sum);
      ptp_time_t   t;
      logic [NS_W:0] ns_wrap;
      ns_wrap = ns_sum - {1'b0, NS_PER_SEC};
      if (ns_sum >= {1'b0, NS_PER_SEC}) begin
         t.sec = sec + 1'b1;
         t.ns  = ns_wrap[NS_W-1:0];
      end else begin
         t.sec = sec;
         t.ns  = ns_sum[NS_W-1:0];
      end
      return t;
   endfunction

   logic [STD_W-1:0]   std_p0;
   logic [FNS_W-1:0]   fns_p0;
   logic [TAG_W-1:0]   tag_p0;
   logic               vld_p0;

   logic [SEC_W-1:0]   sec_p1;
   logic [NS_W:0]      ns_sum_p1;
   logic [FNS_W-1:0]   fns_p1;
   logic [TAG_W-1:0]   tag_p1;
   logic               vld_p1;

   ptp_time_t          time_p2;
   logic [ENTRY_W-1:0] entry_p2;
   logic               vld_p2;

   logic [ENTRY_W-1:0] head;
   logic               drop;
   logic [NS_W:0]      lat_add;

   assign lat_add = lat_en_i ? {17'd0, lat_ns_i} : '0;

   always_ff @(posedge rtc_clk or negedge rtc_rst_n) begin
      if (!rtc_rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         ovf_o  <= 1'b0;
      end else begin
         vld_p0 <= sof_i;
         vld_p1 <= vld_p0;
         // A fresh overflow outranks a coincident clear.
         if (drop)
            ovf_o <= 1'b1;
         else if (ovf_clr_i)
            ovf_o <= 1'b0;
      end
   end

   // S0: snapshot time and tag on the strobe
   always_ff @(posedge rtc_clk) begin
      if (sof_i) begin
         std_p0 <= rtc_std_i;
         fns_p0 <= rtc_fns_i;
         tag_p0 <= tag_i;
      end
   end

   // S1: add latency correction
   always_ff @(posedge rtc_clk) begin
      if (vld_p0) begin
         sec_p1    <= std_p0[STD_W-1:NS_W];
         ns_sum_p1 <= {1'b0, std_p0[NS_W-1:0]} + lat_add;
         fns_p1    <= fns_p0;
         tag_p1    <= tag_p0;
      end
   end

   // S2: normalise ns overflow into seconds and push
   always_comb begin
      time_p2  = normalize(sec_p1, ns_sum_p1);
      entry_p2 = {time_p2.sec, time_p2.ns, fns_p1, tag_p1};
      vld_p2   = vld_p1;
   end

   ptp_ts_fifo #(
      .WIDTH (ENTRY_W),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (rtc_clk),
      .rst_n   (rtc_rst_n),
      .push    (vld_p2),
      .din     (entry_p2),
      .pop_req (ts_ready_i),
      .valid   (ts_valid_o),
      .dout    (head),
      .cnt     (fifo_cnt_o),
      .drop    (drop)
   );

   assign ts_std_o = head[ENTRY_W-1 -: STD_W];
   assign ts_fns_o = head[TAG_W +: FNS_W];
   assign ts_tag_o = head[TAG_W-1:0];

endmodule

// File: tb/tb_ptp_ts_capture.sv
// Directed bench for ptp_ts_capture: latency, carry, second wrap, overflow,
// full-with-pop acceptance and mid-stream reset.
module tb_ptp_ts_capture;

   logic          rtc_clk;
   logic          rtc_rst_n;
   logic [79:0]   rtc_std_i;
   logic [15:0]   rtc_fns_i;
   logic          sof_i;
   logic [15:0]   tag_i;
   logic          lat_en_i;
   logic [15:0]   lat_ns_i;
   logic          ts_ready_i;
   logic          ts_valid_o;
   logic [79:0]   ts_std_o;
   logic [15:0]   ts_fns_o;
   logic [15:0]   ts_tag_o;
   logic [2:0]    fifo_cnt_o;
   logic          ovf_o;
   logic          ovf_clr_i;

   int n_assert = 0;
   int n_fail   = 0;

   ptp_ts_capture #(.FIFO_AW(2), .TAG_W(16)) dut (
      .rtc_clk    (rtc_clk),
      .rtc_rst_n  (rtc_rst_n),
      .rtc_std_i  (rtc_std_i),
      .rtc_fns_i  (rtc_fns_i),
      .sof_i      (sof_i),
      .tag_i      (tag_i),
      .lat_en_i   (lat_en_i),
      .lat_ns_i   (lat_ns_i),
      .ts_ready_i (ts_ready_i),
      .ts_valid_o (ts_valid_o),
      .ts_std_o   (ts_std_o),
      .ts_fns_o   (ts_fns_o),
      .ts_tag_o   (ts_tag_o),
      .fifo_cnt_o (fifo_cnt_o),
      .ovf_o      (ovf_o),
      .ovf_clr_i  (ovf_clr_i)
   );

   initial rtc_clk = 1'b0;
   always #5 rtc_clk = ~rtc_clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge rtc_clk);
      #1;
   endtask

   task automatic send(input logic [15:0] tag, input logic [47:0] sec,
                       input logic [31:0] ns, input logic [15:0] fns);
      rtc_std_i = {sec, ns};
      rtc_fns_i = fns;
      tag_i     = tag;
      sof_i     = 1'b1;
      tick();
      sof_i     = 1'b0;
   endtask

   task automatic pop_one();
      ts_ready_i = 1'b1;
      tick();
      ts_ready_i = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, ts_valid_o, 0);
      chk({tag, "_std"}, ts_std_o, 0);
      chk({tag, "_fns"}, ts_fns_o, 0);
      chk({tag, "_tag"}, ts_tag_o, 0);
      chk({tag, "_cnt"}, fifo_cnt_o, 0);
      chk({tag, "_ovf"}, ovf_o, 0);
   endtask

   initial begin
      rtc_rst_n  = 1'b0;
      rtc_std_i  = '0;
      rtc_fns_i  = '0;
      sof_i      = 1'b0;
      tag_i      = '0;
      lat_en_i   = 1'b1;
      lat_ns_i   = 16'd250;
      ts_ready_i = 1'b0;
      ovf_clr_i  = 1'b0;
      #12;
      chk_all_zero("reset");
      tick();
      rtc_rst_n = 1'b1;
      tick();

      // single capture: 3-cycle latency, ns + 250
      send(16'h0012, 48'd5, 32'd100, 16'hABCD);
      tick();
      chk("lat_n2_valid", ts_valid_o, 0);
      tick();
      chk("lat_n3_valid", ts_valid_o, 1);
      chk("single_std", ts_std_o, {48'd5, 32'd350});
      chk("single_fns", ts_fns_o, 16'hABCD);
      chk("single_tag", ts_tag_o, 16'h0012);
      chk("single_cnt", fifo_cnt_o, 1);
      pop_one();
      chk("single_pop_valid", ts_valid_o, 0);
      chk("single_pop_cnt", fifo_cnt_o, 0);
      pop_one();
      chk("empty_pop_cnt", fifo_cnt_o, 0);

      // ns carry into seconds
      lat_ns_i = 16'd200;
      send(16'h0020, 48'd7, 32'd999_999_900, 16'h0001);
      tick(); tick();
      chk("carry_std", ts_std_o, {48'd8, 32'd100});
      pop_one();

      // seconds wrap
      lat_ns_i = 16'd1;
      send(16'h0030, 48'hFFFF_FFFF_FFFF, 32'd999_999_999, 16'h0002);
      tick(); tick();
      chk("wrap_std", ts_std_o, {48'd0, 32'd0});
      pop_one();
      lat_en_i = 1'b0;
      send(16'h0031, 48'hFFFF_FFFF_FFFF, 32'd999_999_999, 16'h0003);
      tick(); tick();
      chk("lat_dis_std", ts_std_o, {48'hFFFF_FFFF_FFFF, 32'd999_999_999});
      pop_one();
      lat_en_i = 1'b1;
      lat_ns_i = 16'd250;

      // five back-to-back strobes into a depth-4 queue
      for (int k = 1; k <= 5; k++)
         send(16'(k), 48'(k), 32'(k * 1000), 16'(k));
      chk("ovf_before_drop", ovf_o, 0);
      tick(); tick();
      chk("ovf_set", ovf_o, 1);
      chk("ovf_cnt", fifo_cnt_o, 4);
      chk("ovf_head_tag", ts_tag_o, 16'd1);
      chk("ovf_head_std", ts_std_o, {48'd1, 32'd1250});
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      chk("ovf_clear", ovf_o, 0);
      for (int k = 1; k <= 4; k++) begin
         chk("drain_tag", ts_tag_o, 128'(k));
         pop_one();
      end
      chk("drain_valid", ts_valid_o, 0);
      chk("drain_cnt", fifo_cnt_o, 0);

      // full queue, pop and push in the same cycle
      for (int k = 0; k < 4; k++)
         send(16'(16'h21 + k), 48'd9, 32'd0, 16'd0);
      tick(); tick();
      chk("full_cnt", fifo_cnt_o, 4);
      send(16'h0025, 48'd9, 32'd0, 16'd0);
      tick();
      ts_ready_i = 1'b1;
      tick();
      ts_ready_i = 1'b0;
      chk("pp_cnt", fifo_cnt_o, 4);
      chk("pp_ovf", ovf_o, 0);
      chk("pp_head", ts_tag_o, 16'h0022);
      tick();
      chk("pp_ovf_late", ovf_o, 0);
      for (int k = 0; k < 4; k++) begin
         chk("pp_drain_tag", ts_tag_o, 128'(16'h22 + k));
         pop_one();
      end
      chk("pp_drain_valid", ts_valid_o, 0);

      // reset with two queued and one in flight
      send(16'h0031, 48'd3, 32'd10, 16'h0011);
      send(16'h0032, 48'd3, 32'd20, 16'h0022);
      tick(); tick();
      chk("pre_rst_cnt", fifo_cnt_o, 2);
      send(16'h0033, 48'd3, 32'd30, 16'h0033);
      rtc_rst_n = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      tick();
      rtc_rst_n = 1'b1;
      tick(); tick(); tick();
      chk("post_rst_valid", ts_valid_o, 0);
      chk("post_rst_cnt", fifo_cnt_o, 0);
      send(16'h0034, 48'd4, 32'd40, 16'h0044);
      tick(); tick();
      chk("post_rst_new_valid", ts_valid_o, 1);
      chk("post_rst_new_tag", ts_tag_o, 16'h0034);
      chk("post_rst_new_std", ts_std_o, {48'd4, 32'd290});
      chk("post_rst_new_cnt", fifo_cnt_o, 1);
      tick();
      chk("post_rst_alone_cnt", fifo_cnt_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ptp_ts_capture.md
Name: ptp_ts_capture

Overview:
- Downstream consumer of the RTC time bus in the rtc_clk domain.
- On each MAC start-of-frame strobe, snapshots the 80-bit current time and the 16-bit fractional ns, and adds a programmable PHY/pipeline latency correction with ns-to-seconds carry.
- Tags each timestamp with a frame sequence ID and queues it in a small FWFT FIFO for the PTP parser/host to drain.
- Flags overflow when the queue cannot accept a timestamp.

Parameters:
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (4).
- TAG_W, 16, width of the frame tag (PTP sequenceId).

Ports:
- rtc_clk  in  1  RTC clock.
- rtc_rst_n  in  1  reset.
- rtc_std_i  in  80  current time {48b sec, 32b ns}.
- rtc_fns_i  in  16  current fractional ns.
- sof_i  in  1  start-of-frame strobe, 1-cycle pulse.
- tag_i  in  TAG_W  tag, valid with sof_i.
- lat_en_i  in  1  enable latency correction.
- lat_ns_i  in  16  latency correction in ns, quasi-static.
- ts_ready_i  in  1  consumer pop request.
- ts_valid_o  out  1  FIFO head valid.
- ts_std_o  out  80  head timestamp {sec, ns}.
- ts_fns_o  out  16  head fractional ns.
- ts_tag_o  out  TAG_W  head tag.
- fifo_cnt_o  out  FIFO_AW+1  occupancy.
- ovf_o  out  1  sticky overflow flag.
- ovf_clr_i  in  1  clear ovf_o.

Behaviour:
- Clock and reset: rtc_clk; reset rtc_rst_n, asynchronous, active-low.
- Reset values: all outputs 0. Pipeline valids, FIFO pointers and count are cleared.
- A reset in the middle of operation discards any in-flight and queued timestamps. No partial entry survives.

Pipeline:
- S0 (sof_i cycle): register rtc_std_i, rtc_fns_i and tag_i; set v1.
- S1: ns_sum (33b) = ns + (lat_en_i ? lat_ns_i : 0). Carry sec and fns through; set v2.
- S2: if ns_sum >= 1_000_000_000, then ns = ns_sum - 1e9 and sec = sec + 1 (48-bit wrap, 0xFFFF_FFFF_FFFF+1 -> 0). Otherwise ns = ns_sum. Push {sec, ns, fns, tag} to the FIFO.
- The input ns is guaranteed < 1e9 and lat_ns_i < 2^16, so at most one correction step is needed.
- Latency: sof_i at cycle N gives ts_valid_o = 1 at cycle N+3 when the FIFO was empty.
- Back-to-back sof_i on consecutive cycles is fully supported, one entry per strobe, in order.

FIFO:
- FWFT: head data is presented on the ts_* outputs whenever ts_valid_o = 1.
- Pop occurs when ts_valid_o & ts_ready_i. The next entry (or 0 valid) appears the following cycle.
- ts_ready_i while empty has no effect.
- Push is accepted if not full, or if full and a pop occurs in the same cycle.
- Simultaneous push and pop leaves fifo_cnt_o unchanged.
- Push while full without a pop: the new timestamp is dropped, queue contents are unchanged, and ovf_o is set the next cycle.
- ovf_o holds until ovf_clr_i. If ovf_clr_i and a new overflow coincide, set wins.
- Pointers wrap modulo depth. fifo_cnt_o ranges 0..2**FIFO_AW.

Decomposition:
- Shared package/defines (ptpv2_defines): NS_PER_SEC = 32'd1_000_000_000, SEC_W = 48, NS_W = 32, FNS_W = 16, STD_W = 80.
- One natural sub-module: ptp_ts_fifo (generic sync FWFT FIFO, parameterised width/depth, count output). Reusable for egress timestamps.
- The capture/correction pipeline stays in the top.

Test Plan:
- Reset, then a single sof_i with tag=0x0012, rtc_std={sec 5, ns 100}, lat_en=1, lat=250 -> cycle N+3: ts_valid=1, ts_std={5, 350}, ts_tag=0x0012, fifo_cnt=1. Pop -> ts_valid=0.
- Carry: ns=999_999_900, lat=200, sec=7 -> ts_std={8, 100}.
- Second wrap: sec=0xFFFF_FFFF_FFFF, ns=999_999_999, lat=1 -> sec=0, ns=0. With lat_en=0 the ns is unchanged.
- Five back-to-back sof_i (tags 1..5), no pops, depth 4 -> tags 1..4 are queued, tag 5 is dropped, ovf_o=1, fifo_cnt=4. ovf_clr_i -> ovf_o=0.
- FIFO full with ts_ready_i=1 and a push landing in the same cycle -> head pops, new entry is accepted, fifo_cnt stays 4, ovf_o stays 0.
- Assert rtc_rst_n mid-stream with 2 entries queued and 1 in flight -> all outputs 0. After release, the first new sof appears alone with fifo_cnt=1.
